serial_frame_receiver: RTL and testbench

//  Parametrised successor to the fixed 40-bit serial receiver: start-bit framed serial input,

---
 rtl/serial_frame_receiver.sv | 136 +++++++++++++
 tb/tb_serial_frame_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// rtl/serial_frame_receiver.sv - start-bit framed serial receiver with one-entry valid/ready output buffer
// Optional feature macro: SERIAL_FRAME_RECEIVER_PARITY_EN (adds an even-parity bit after the payload)
// Ports:
//   clk          single clock, all logic on posedge
//   rst_n        asynchronous active-low reset
//   si           serial in, idle low, start bit = 1
//   out_data     buffered payload
//   out_valid    out_data holds an unconsumed frame
//   out_ready    consumer accepts out_data when out_valid && out_ready
//   overrun      sticky: a completed frame was dropped because the buffer was full
//   overrun_clr  clears overrun (a same-cycle drop wins)
//   busy         receiver is not idle
//   parity_err   buffered frame had odd parity (0 when parity is disabled)
module serial_frame_receiver #(
  parameter int DATA_BITS  = 40,
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 si,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 overrun,
  input  logic                 overrun_clr,
  output logic                 busy,
  output logic                 parity_err
);

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  localparam int CW = $clog2(DATA_BITS + 2);
  localparam logic [CW-1:0] DATA_CNT = CW'(DATA_BITS);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BITS + PAR_BITS - 1);
  localparam logic [3:0]    GAP_LAST = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [3:0]           gap_cnt, gap_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 frame_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      gap_cnt <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      gap_cnt <= gap_cnt_nxt;
      shreg   <= shreg_nxt;
    end
  end

  // shreg_nxt is the complete payload on the completing edge, so it is loaded
  // straight into out_data without an extra cycle. With parity the last sample
  // is the parity bit, which is not shifted in (cnt has reached DATA_CNT).
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    gap_cnt_nxt = gap_cnt;
    shreg_nxt   = shreg;
    frame_done  = 1'b0;
    case (state)
      IDLE: begin
        if (si) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        if (cnt < DATA_CNT) begin
          if (MSB_FIRST) shreg_nxt = {shreg[DATA_BITS-2:0], si};
          else           shreg_nxt = {si, shreg[DATA_BITS-1:1]};
        end
        if (cnt == LAST_CNT) begin
          frame_done  = 1'b1;
          cnt_nxt     = '0;
          gap_cnt_nxt = '0;
          state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_nxt = IDLE;
        else                     gap_cnt_nxt = gap_cnt + 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // A completing frame may replace a buffered frame only if that frame is
  // being consumed on the same edge; otherwise the new frame is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_done && (!out_valid || out_ready)) begin
        out_data  <= shreg_nxt;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (frame_done && out_valid && !out_ready) overrun <= 1'b1;
      else if (overrun_clr)                      overrun <= 1'b0;
    end
  end

`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  // Even parity over payload + parity bit: an odd count of ones is an error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (frame_done && (!out_valid || out_ready)) begin
      parity_err <= (^shreg) ^ si;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_receiver.sv
// tb/tb_serial_frame_receiver.sv - scoreboard bench for serial_frame_receiver
module tb_serial_frame_receiver;

  localparam int DB  = 40;
  localparam int GAP = 1;
`ifdef SERIAL_FRAME_RECEIVER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          si = 1'b0;
  logic          out_ready = 1'b0;
  logic          overrun_clr = 1'b0;
  logic [DB-1:0] out_data;
  logic          out_valid;
  logic          overrun;
  logic          busy;
  logic          parity_err;

  always #5 clk = ~clk;

  serial_frame_receiver #(.DATA_BITS(DB), .MSB_FIRST(1'b1), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .si(si),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .overrun_clr(overrun_clr),
    .busy(busy), .parity_err(parity_err)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // driver -> model handshake flags
  bit            start_now = 1'b0;
  bit            last_now = 1'b0;
  logic [DB-1:0] cur_frame = '0;
  bit            cur_perr = 1'b0;
  bit            rand_mode = 1'b0;

  // reference model: one-entry buffer occupancy, sticky overrun, busy window
  logic [DB:0]   exp_q[$];
  bit            model_occ = 1'b0;
  bit            exp_ovr = 1'b0;
  bit            drop = 1'b0;
  int            busy_cnt = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      model_occ = 1'b0;
      exp_ovr   = 1'b0;
      busy_cnt  = 0;
    end else begin
      drop = 1'b0;
      if (last_now) begin
        if (!model_occ || out_ready) begin
          exp_q.push_back({cur_perr, cur_frame});
          model_occ = 1'b1;
        end else begin
          drop = 1'b1;
        end
      end else if (model_occ && out_ready) begin
        model_occ = 1'b0;
      end
      if (drop) exp_ovr = 1'b1;
      else if (overrun_clr) exp_ovr = 1'b0;
      if (start_now) busy_cnt = DB + PB + GAP;
      else if (busy_cnt > 0) busy_cnt--;
    end
  end

  // monitor: compares every cycle, pops the scoreboard on each new presentation
  bit            last_valid = 1'b0;
  logic [DB-1:0] last_data = '0;
  logic [DB:0]   e;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      last_valid = 1'b0;
    end else begin
      check("valid", 64'(out_valid), 64'(model_occ));
      check("overrun", 64'(overrun), 64'(exp_ovr));
      check("busy", 64'(busy), 64'(busy_cnt > 0));
      if (out_valid && (!last_valid || out_ready)) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_frame: got %h want none at %0t", out_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("data", 64'(out_data), 64'(e[DB-1:0]));
          check("parity_err", 64'(parity_err), 64'(e[DB]));
        end
      end else if (out_valid) begin
        check("stable", 64'(out_data), 64'(last_data));
      end
      last_valid = out_valid;
      last_data  = out_data;
    end
  end

  always @(negedge clk) begin
    if (rand_mode) begin
      out_ready   = ($urandom_range(0, 2) != 0);
      overrun_clr = ($urandom_range(0, 15) == 0);
    end
  end

  // ready_last: -1 leaves out_ready alone, 0/1 drives it for the completing edge
  task automatic send_frame(input logic [DB-1:0] d, input int idle_after, input int ready_last);
    bit pbit;
    @(negedge clk);
    last_now  = 1'b0;
    cur_frame = d;
    cur_perr  = 1'b0;
    si        = 1'b1;
    start_now = 1'b1;
    for (int i = 0; i < DB; i++) begin
      @(negedge clk);
      start_now = 1'b0;
      si        = d[DB-1-i];
      last_now  = (PB == 0) && (i == DB - 1);
    end
    if (PB != 0) begin
      pbit     = 1'($urandom_range(0, 1));
      cur_perr = (^d) ^ pbit;
      @(negedge clk);
      si       = pbit;
      last_now = 1'b1;
    end
    if (ready_last >= 0) out_ready = ready_last[0];
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      last_now = 1'b0;
      si       = 1'($urandom_range(0, 1));
    end
    for (int n = 0; n < idle_after; n++) begin
      @(negedge clk);
      last_now = 1'b0;
      si       = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      last_now  = 1'b0;
      start_now = 1'b0;
      si        = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_data"}, 64'(out_data), 64'(0));
    check({tag, "_overrun"}, 64'(overrun), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_parity_err"}, 64'(parity_err), 64'(0));
  endtask

  localparam logic [DB-1:0] FA = 40'hA9F0AAAAA9;
  localparam logic [DB-1:0] FB = 40'h0123456789;

  logic [63:0] r;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // same frame twice, consumer always ready
    out_ready = 1'b1;
    send_frame(FA, 3, -1);
    send_frame(FA, 3, -1);
    idle(2);

    // consumer stalled: second frame dropped, overrun set, then cleared
    out_ready = 1'b0;
    send_frame(FA, 0, -1);
    send_frame(FB, 2, -1);
    check("t3_hold_data", 64'(out_data), 64'(FA));
    check("t3_overrun", 64'(overrun), 64'(1));
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    #1;
    check("t3_overrun_clr", 64'(overrun), 64'(0));
    out_ready = 1'b1;
    idle(3);

    // second frame completes on the edge that consumes the first
    out_ready = 1'b0;
    send_frame(FA, 0, -1);
    send_frame(FB, 0, 1);
    check("t4_data", 64'(out_data), 64'(FB));
    idle(3);

    // reset mid-frame, then a clean frame
    @(negedge clk);
    si = 1'b1;
    start_now = 1'b1;
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      start_now = 1'b0;
      si = 1'($urandom_range(0, 1));
    end
    rst_n = 1'b0;
    si = 1'b0;
    #1;
    check_reset_outputs("t5_async");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_outputs("t5_after");
    idle(2);
    send_frame(FB, 3, -1);

    // randomized traffic with random back-pressure and overrun clears
    rand_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      r = {$urandom(), $urandom()};
      send_frame(r[DB-1:0], $urandom_range(0, 3), -1);
    end
    idle(1);
    rand_mode   = 1'b0;
    out_ready   = 1'b1;
    overrun_clr = 1'b0;
    idle(6);
    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
